// File: rtl/small_fifo_v2_if.sv
// small_fifo_v2_if: data/strobe/status bundle for small_fifo_v2.
// master drives writes and reads, slave is the FIFO itself.
interface small_fifo_v2_if #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic                    err_clr;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    nearly_full;
  logic                    empty;
  logic                    nearly_empty;
  logic [MAX_DEPTH_BITS:0] count;
  logic                    overflow;
  logic                    underflow;
  logic [MAX_DEPTH_BITS:0] hwm;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, full, nearly_full, empty,
    input  nearly_empty, count,
    input  overflow, underflow, hwm
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, full, nearly_full, empty,
    output nearly_empty, count,
    output overflow, underflow, hwm
  );
endinterface

// File: rtl/small_fifo_v2.sv
// small_fifo_v2: sync FIFO, registered or FWFT read, sticky errors.
// Define SMALL_FIFO_HWM_EN to build the high-water-mark register.
module small_fifo_v2 #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS-1,
  parameter int NEARLY_EMPTY   = 1,
  parameter int FWFT           = 0
) (
  input logic            clk,
  input logic            reset,
  small_fifo_v2_if.slave bus
);
  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  typedef logic [MAX_DEPTH_BITS-1:0] ptr_t;
  typedef logic [CW-1:0]             cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             cnt;
  cnt_t             cnt_nxt;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;
  logic             udf_q;

  logic empty_w;
  logic full_w;
  logic rd_acc;
  logic wr_acc;
  logic ram_wr;
  logic ram_rd;
  logic byp;

  assign full_w = (cnt == cnt_t'(DEPTH));
  assign rd_acc = bus.rd_en & ~empty_w;
  assign wr_acc = bus.wr_en & (~full_w | rd_acc);

  // Read-side flavour: where dout comes from and when it is empty
  if (FWFT != 0) begin : g_fwft
    logic ov;
    logic load;
    cnt_t ram_cnt;

    assign empty_w = ~ov;
    assign ram_cnt = cnt - cnt_t'(ov);
    assign load    = ~ov | rd_acc;
    assign ram_rd  = load & (ram_cnt != '0);
    assign byp     = load & (ram_cnt == '0) & wr_acc;
    assign ram_wr  = wr_acc & ~byp;

    // Output stage valid: refilled from RAM or bypassed write
    always_ff @(posedge clk) begin
      if (reset) begin
        ov <= 1'b0;
      end else if (load) begin
        ov <= ram_rd | byp;
      end
    end
  end else begin : g_reg
    assign empty_w = (cnt == '0);
    assign ram_rd  = rd_acc;
    assign byp     = 1'b0;
    assign ram_wr  = wr_acc;
  end

  // Occupancy next value; accepted ops only
  always_comb begin
    cnt_nxt = cnt;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + cnt_t'(1);
      2'b01:   cnt_nxt = cnt - cnt_t'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Storage array, no reset so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (!reset && ram_wr) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  // Pointers, count and read data register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (ram_wr) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
        dout_q <= mem[rd_ptr];
      end else if (byp) begin
        dout_q <= bus.din;
      end
    end
  end

  // Sticky errors; a fresh error beats err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.err_clr)
             | (bus.wr_en & ~wr_acc);
      udf_q <= (udf_q & ~bus.err_clr)
             | (bus.rd_en & ~rd_acc);
    end
  end

`ifdef SMALL_FIFO_HWM_EN
  cnt_t hwm_q;

  // Peak occupancy since reset or err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_q <= '0;
    end else if (bus.err_clr) begin
      hwm_q <= cnt_nxt;
    end else if (cnt_nxt > hwm_q) begin
      hwm_q <= cnt_nxt;
    end
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif

  assign bus.dout         = dout_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.count        = cnt;
  assign bus.nearly_full  = (cnt >= cnt_t'(NEARLY_FULL));
  assign bus.nearly_empty = (cnt <= cnt_t'(NEARLY_EMPTY));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
